// File: rtl/rf_pkg.sv
// Shared definitions for the register file and its busy scoreboard:
// default sizes, a constant-foldable clog2, address/data typedefs and
// a helper that says whether an address names a real, writable register.
package rf_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int NUM_REGS_DEF = 32;

    // Ceiling log2, usable in parameter expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    localparam int RF_ADR_W_DEF = clog2(NUM_REGS_DEF);

    typedef logic [RF_ADR_W_DEF-1:0] rf_adr_t;
    typedef logic [DATA_W_DEF-1:0]   rf_data_t;

    localparam int ZERO_ADR = 0;

    // True when the address is inside the file and is not a hardwired-zero R0.
    // Such addresses hold data, can be written and can be reserved.
    function automatic logic rf_tracked(input int adr, input int num_regs, input bit zero_reg);
        return (adr < num_regs) && !(zero_reg && (adr == ZERO_ADR));
    endfunction

endpackage

// File: rtl/rf_busy_table.sv
// Per-register busy scoreboard. Issue reserves a destination, writeback
// releases it, flush squashes everything. Also reports RAW hazards on the
// read ports, WAW refusal on the reserve port and a registered busy count
// that always equals the number of set busy bits.
module rf_busy_table
    import rf_pkg::*;
#(
    parameter  int NUM_REGS = NUM_REGS_DEF,
    parameter  int NUM_RD   = 2,
    parameter  int ZERO_REG = 1,
    localparam int ADR_W    = clog2(NUM_REGS),
    localparam int CNT_W    = clog2(NUM_REGS + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_RD*ADR_W-1:0] rd_adr,
    output logic [NUM_RD-1:0]       rd_busy,
    input  logic                    wr_en,
    input  logic [ADR_W-1:0]        wr_adr,
    input  logic                    rsv_en,
    input  logic [ADR_W-1:0]        rsv_adr,
    output logic                    rsv_ready,
    input  logic                    flush,
    output logic [CNT_W-1:0]        busy_count
);

    // Busy bits padded out to the full address space so out-of-range
    // addresses index a constant zero instead of running off the vector.
    localparam int ADR_SPAN = 1 << ADR_W;

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [CNT_W-1:0]    count_q;
    logic [CNT_W-1:0]    count_d;
    logic [ADR_SPAN-1:0] busy_ext;

    logic wr_hit;
    logic rsv_tracked;
    logic accept;
    logic cnt_inc;
    logic cnt_dec;

    genvar gi;

    // Zero-extend the busy vector to cover every encodable address.
    always_comb begin
        busy_ext                 = '0;
        busy_ext[NUM_REGS-1:0]   = busy_q;
    end

    assign wr_hit      = wr_en && rf_tracked(int'(wr_adr), NUM_REGS, ZERO_REG != 0);
    assign rsv_tracked = rf_tracked(int'(rsv_adr), NUM_REGS, ZERO_REG != 0);

    // A pending write to the same register in this cycle resolves the hazard,
    // so a same-cycle writeback makes the destination reservable again.
    assign rsv_ready = !rsv_tracked || !busy_ext[rsv_adr] || (wr_hit && (wr_adr == rsv_adr));
    assign accept    = rsv_en && rsv_ready && !flush && rsv_tracked;

    // Read-port hazard flags; a same-cycle write is bypassed, so it is not a hazard.
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd_busy
        logic [ADR_W-1:0] adr;
        assign adr         = rd_adr[gi*ADR_W +: ADR_W];
        assign rd_busy[gi] = busy_ext[adr] && !(wr_en && (wr_adr == adr));
    end

    // Next busy vector: release on write, then set on accepted reserve, flush wins.
    always_comb begin
        busy_d = busy_q;
        if (wr_hit) begin
            busy_d[wr_adr] = 1'b0;
        end
        if (accept) begin
            busy_d[rsv_adr] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
    end

    // Count tracks bit transitions: a reserve only adds when the bit was clear,
    // a write only subtracts when it clears a bit the reserve does not re-set.
    always_comb begin
        cnt_inc = accept && !busy_ext[rsv_adr];
        cnt_dec = wr_hit && busy_ext[wr_adr] && !(accept && (rsv_adr == wr_adr));
        if (flush) begin
            count_d = '0;
        end else begin
            count_d = count_q + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
        end
    end

    // Busy state and count registers; reset drops every reservation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign busy_count = count_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// General-purpose register file with combinational read ports, one
// synchronous write port with write-to-read bypass, optional hardwired-zero
// R0, and a busy scoreboard for RAW/WAW tracking between issue and writeback.
module regfile_scoreboard
    import rf_pkg::*;
#(
    parameter  int DATA_W   = DATA_W_DEF,
    parameter  int NUM_REGS = NUM_REGS_DEF,
    parameter  int NUM_RD   = 2,
    parameter  int ZERO_REG = 1,
    localparam int ADR_W    = clog2(NUM_REGS),
    localparam int CNT_W    = clog2(NUM_REGS + 1)
) (
    input  logic                     Clock,
    input  logic                     Reset_n,
    input  logic [NUM_RD*ADR_W-1:0]  Rd_Adr,
    output logic [NUM_RD*DATA_W-1:0] Rd_Data,
    output logic [NUM_RD-1:0]        Rd_Busy,
    input  logic                     Wr_En,
    input  logic [ADR_W-1:0]         Wr_Adr,
    input  logic [DATA_W-1:0]        Wr_Data,
    input  logic                     Rsv_En,
    input  logic [ADR_W-1:0]         Rsv_Adr,
    output logic                     Rsv_Ready,
    input  logic                     Flush,
    output logic [CNT_W-1:0]         Busy_Count
);

    logic [DATA_W-1:0] data_q [NUM_REGS];
    logic [DATA_W-1:0] data_d [NUM_REGS];
    logic              wr_hit;

    genvar gi;

    assign wr_hit = Wr_En && rf_tracked(int'(Wr_Adr), NUM_REGS, ZERO_REG != 0);

    // Write port: R0 (when hardwired) and out-of-range addresses are dropped.
    always_comb begin
        data_d = data_q;
        if (wr_hit) begin
            data_d[Wr_Adr] = Wr_Data;
        end
    end

    // Register array; kept in flops because reset must clear every entry.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            data_q <= data_d;
        end
    end

    // Read ports: zero for untracked addresses or during reset, otherwise
    // forward the in-flight write before falling back to the stored value.
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd_port
        logic [ADR_W-1:0]  adr;
        logic [DATA_W-1:0] rd_val;
        logic              tracked;

        assign adr     = Rd_Adr[gi*ADR_W +: ADR_W];
        assign tracked = rf_tracked(int'(adr), NUM_REGS, ZERO_REG != 0);

        // Read mux with bypass priority.
        always_comb begin
            rd_val = '0;
            if (!Reset_n || !tracked) begin
                rd_val = '0;
            end else if (Wr_En && (Wr_Adr == adr)) begin
                rd_val = Wr_Data;
            end else begin
                rd_val = data_q[adr];
            end
        end

        assign Rd_Data[gi*DATA_W +: DATA_W] = rd_val;
    end

    rf_busy_table #(
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG)
    ) u_busy_table (
        .clk        (Clock),
        .rst_n      (Reset_n),
        .rd_adr     (Rd_Adr),
        .rd_busy    (Rd_Busy),
        .wr_en      (Wr_En),
        .wr_adr     (Wr_Adr),
        .rsv_en     (Rsv_En),
        .rsv_adr    (Rsv_Adr),
        .rsv_ready  (Rsv_Ready),
        .flush      (Flush),
        .busy_count (Busy_Count)
    );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard. Two instances share one stimulus bus:
// A = 32 regs, 2 read ports, hardwired R0; B = 24 regs, 3 read ports, plain R0.
// Directed table on A, hand sequences for reset and out-of-range/R0 on B,
// then randomized traffic on both against an array-based reference model.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [4:0]  wr_adr;
    logic [31:0] wr_data;
    logic        rsv_en;
    logic [4:0]  rsv_adr;
    logic        flush;
    logic [14:0] rd_adr;

    logic [63:0] rd_data_a;
    logic [1:0]  rd_busy_a;
    logic        rsv_ready_a;
    logic [5:0]  busy_count_a;

    logic [95:0] rd_data_b;
    logic [2:0]  rd_busy_b;
    logic        rsv_ready_b;
    logic [4:0]  busy_count_b;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state, one slot per instance.
    logic [31:0] mdl_data [2][32];
    bit          mdl_busy [2][32];

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        re;
        logic [4:0]  ra;
        logic        fl;
        logic [4:0]  rd0;
        logic [31:0] erd;
        logic        eb;
        logic        ery;
        int          ecnt;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    regfile_scoreboard #(
        .DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .ZERO_REG(1)
    ) dut_a (
        .Clock(clk), .Reset_n(rst_n), .Rd_Adr(rd_adr[9:0]), .Rd_Data(rd_data_a),
        .Rd_Busy(rd_busy_a), .Wr_En(wr_en), .Wr_Adr(wr_adr), .Wr_Data(wr_data),
        .Rsv_En(rsv_en), .Rsv_Adr(rsv_adr), .Rsv_Ready(rsv_ready_a), .Flush(flush),
        .Busy_Count(busy_count_a)
    );

    regfile_scoreboard #(
        .DATA_W(32), .NUM_REGS(24), .NUM_RD(3), .ZERO_REG(0)
    ) dut_b (
        .Clock(clk), .Reset_n(rst_n), .Rd_Adr(rd_adr), .Rd_Data(rd_data_b),
        .Rd_Busy(rd_busy_b), .Wr_En(wr_en), .Wr_Adr(wr_adr), .Wr_Data(wr_data),
        .Rsv_En(rsv_en), .Rsv_Adr(rsv_adr), .Rsv_Ready(rsv_ready_b), .Flush(flush),
        .Busy_Count(busy_count_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int m_nregs(input int k);
        return (k == 0) ? 32 : 24;
    endfunction

    function automatic int m_nrd(input int k);
        return (k == 0) ? 2 : 3;
    endfunction

    function automatic bit m_tracked(input int k, input int adr);
        if (adr >= m_nregs(k)) return 1'b0;
        if (k == 0 && adr == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] m_rd(input int k, input int adr);
        if (!m_tracked(k, adr)) return 32'h0;
        if (wr_en && int'(wr_adr) == adr) return wr_data;
        return mdl_data[k][adr];
    endfunction

    function automatic bit m_busy(input int k, input int adr);
        if (!m_tracked(k, adr)) return 1'b0;
        return mdl_busy[k][adr] && !(wr_en && int'(wr_adr) == adr);
    endfunction

    function automatic bit m_ready(input int k);
        int a;
        a = int'(rsv_adr);
        if (!m_tracked(k, a)) return 1'b1;
        return !mdl_busy[k][a] || (wr_en && int'(wr_adr) == a);
    endfunction

    function automatic int m_count(input int k);
        int c;
        c = 0;
        for (int r = 0; r < 32; r++) c += mdl_busy[k][r] ? 1 : 0;
        return c;
    endfunction

    task automatic m_clear();
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 32; r++) begin
                mdl_data[k][r] = 32'h0;
                mdl_busy[k][r] = 1'b0;
            end
        end
    endtask

    task automatic m_update(input int k);
        bit rdy;
        rdy = m_ready(k);
        if (wr_en && m_tracked(k, int'(wr_adr))) begin
            mdl_data[k][wr_adr] = wr_data;
            mdl_busy[k][wr_adr] = 1'b0;
        end
        if (flush) begin
            for (int r = 0; r < 32; r++) mdl_busy[k][r] = 1'b0;
        end else if (rsv_en && rdy && m_tracked(k, int'(rsv_adr))) begin
            mdl_busy[k][rsv_adr] = 1'b1;
        end
    endtask

    // One clock with current inputs: check combinational outputs, advance model, check count.
    task automatic step();
        int          a;
        logic [31:0] d;
        logic        b;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < m_nrd(k); p++) begin
                a = int'(rd_adr[p*5 +: 5]);
                d = (k == 0) ? rd_data_a[p*32 +: 32] : rd_data_b[p*32 +: 32];
                b = (k == 0) ? rd_busy_a[p] : rd_busy_b[p];
                check($sformatf("k%0d rd%0d data adr %0d", k, p, a), 64'(d), 64'(m_rd(k, a)));
                check($sformatf("k%0d rd%0d busy adr %0d", k, p, a), 64'(b), 64'(m_busy(k, a)));
            end
            check($sformatf("k%0d rsv_ready adr %0d", k, rsv_adr),
                  64'((k == 0) ? rsv_ready_a : rsv_ready_b), 64'(m_ready(k)));
        end
        m_update(0);
        m_update(1);
        @(posedge clk);
        #1;
        check("k0 busy_count", 64'(busy_count_a), 64'(m_count(0)));
        check("k1 busy_count", 64'(busy_count_b), 64'(m_count(1)));
    endtask

    task automatic add_vec(input logic we, input int wa, input logic [31:0] wd,
                           input logic re, input int ra, input logic fl, input int rd0,
                           input logic [31:0] erd, input logic eb, input logic ery, input int ecnt);
        vec_t v;
        v.we = we; v.wa = 5'(wa); v.wd = wd; v.re = re; v.ra = 5'(ra); v.fl = fl;
        v.rd0 = 5'(rd0); v.erd = erd; v.eb = eb; v.ery = ery; v.ecnt = ecnt;
        vecs.push_back(v);
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; wr_adr = '0; wr_data = '0;
        rsv_en = 1'b0; rsv_adr = '0; flush = 1'b0; rd_adr = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();

        //        we wa wd            re ra fl rd0 erd           eb ery cnt
        add_vec(1, 3, 32'hDEADBEEF, 0, 0, 0, 3, 32'hDEADBEEF, 0, 1, 0);
        add_vec(0, 0, 32'h0,        0, 0, 0, 3, 32'hDEADBEEF, 0, 1, 0);
        add_vec(1, 0, 32'h1234,     0, 0, 0, 0, 32'h0,        0, 1, 0);
        add_vec(0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        0, 1, 0);
        add_vec(0, 0, 32'h0,        1, 7, 0, 7, 32'h0,        0, 1, 1);
        add_vec(0, 0, 32'h0,        1, 7, 0, 7, 32'h0,        1, 0, 1);
        add_vec(1, 7, 32'h77,       0, 7, 0, 7, 32'h77,       0, 1, 0);
        add_vec(0, 0, 32'h0,        0, 7, 0, 7, 32'h77,       0, 1, 0);
        add_vec(0, 0, 32'h0,        1, 9, 0, 9, 32'h0,        0, 1, 1);
        add_vec(1, 9, 32'h99,       1, 9, 0, 9, 32'h99,       0, 1, 1);
        add_vec(0, 0, 32'h0,        0, 9, 0, 9, 32'h99,       1, 0, 1);
        add_vec(1, 9, 32'hAA,       0, 9, 0, 9, 32'hAA,       0, 1, 0);
        add_vec(0, 0, 32'h0,        1, 1, 0, 1, 32'h0,        0, 1, 1);
        add_vec(0, 0, 32'h0,        1, 2, 0, 1, 32'h0,        1, 1, 2);
        add_vec(0, 0, 32'h0,        1, 4, 0, 2, 32'h0,        1, 1, 3);
        add_vec(1, 5, 32'h55,       1, 6, 1, 4, 32'h0,        1, 1, 0);
        add_vec(0, 0, 32'h0,        0, 6, 0, 5, 32'h55,       0, 1, 0);
        add_vec(0, 0, 32'h0,        0, 4, 0, 4, 32'h0,        0, 1, 0);

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset count_a", 64'(busy_count_a), 64'd0);
        check("reset count_b", 64'(busy_count_b), 64'd0);
        check("reset rd_data_a", rd_data_a, 64'd0);
        check("reset rsv_ready_a", 64'(rsv_ready_a), 64'd1);
        rst_n = 1'b1;

        // Directed table on instance A; the first row lands on the first edge after release.
        for (int i = 0; i < vecs.size(); i++) begin
            wr_en = vecs[i].we; wr_adr = vecs[i].wa; wr_data = vecs[i].wd;
            rsv_en = vecs[i].re; rsv_adr = vecs[i].ra; flush = vecs[i].fl;
            rd_adr = '0;
            rd_adr[4:0] = vecs[i].rd0;
            @(negedge clk);
            check($sformatf("vec%0d rd_data0", i), 64'(rd_data_a[31:0]), 64'(vecs[i].erd));
            check($sformatf("vec%0d rd_busy0", i), 64'(rd_busy_a[0]), 64'(vecs[i].eb));
            check($sformatf("vec%0d rsv_ready", i), 64'(rsv_ready_a), 64'(vecs[i].ery));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d busy_count", i), 64'(busy_count_a), 64'(vecs[i].ecnt));
            $display("vec %0d: wr=%0d@%0d rsv=%0d@%0d flush=%0d rd0=%0d -> data=0x%0h busy=%0d ready=%0d count=%0d",
                     i, vecs[i].we, vecs[i].wa, vecs[i].re, vecs[i].ra, vecs[i].fl, vecs[i].rd0,
                     rd_data_a[31:0], rd_busy_a[0], rsv_ready_a, busy_count_a);
        end
        idle_inputs();

        // Reset mid-traffic discards reservations and data.
        wr_en = 1'b1; wr_adr = 5'd5; wr_data = 32'h5555; rsv_en = 1'b1; rsv_adr = 5'd5;
        @(posedge clk);
        #1;
        wr_en = 1'b0; rsv_adr = 5'd7;
        @(posedge clk);
        #1;
        check("pre-reset count_a", 64'(busy_count_a), 64'd2);
        rst_n = 1'b0;
        wr_en = 1'b1; wr_adr = 5'd3; wr_data = 32'hCAFE; rsv_en = 1'b1; rsv_adr = 5'd7;
        rd_adr = {5'd7, 5'd5, 5'd3};
        #1;
        check("in-reset rd_data_a", rd_data_a, 64'd0);
        check("in-reset rd_data_b", 64'(rd_data_b), 64'd0);
        check("in-reset count_a", 64'(busy_count_a), 64'd0);
        check("in-reset count_b", 64'(busy_count_b), 64'd0);
        check("in-reset rsv_ready_a", 64'(rsv_ready_a), 64'd1);
        check("in-reset rd_busy_a", 64'(rd_busy_a), 64'd0);
        @(posedge clk);
        #1;
        check("held-reset rd_data_a", rd_data_a, 64'd0);
        check("held-reset count_a", 64'(busy_count_a), 64'd0);
        rst_n = 1'b1;
        idle_inputs();
        rd_adr = {5'd7, 5'd5, 5'd3};
        #1;
        check("post-reset read R3/R5 a", rd_data_a, 64'd0);
        check("post-reset read b", 64'(rd_data_b), 64'd0);
        @(posedge clk);
        #1;
        check("post-reset count_a", 64'(busy_count_a), 64'd0);
        $display("reset sequence: data_a=0x%0h count_a=%0d count_b=%0d", rd_data_a, busy_count_a, busy_count_b);
        m_clear();

        // Instance B: out-of-range reserve/write/read are no-ops.
        wr_en = 1'b1; wr_adr = 5'd30; wr_data = 32'h3030; rsv_en = 1'b1; rsv_adr = 5'd30;
        rd_adr = {5'd30, 5'd30, 5'd30};
        #1;
        check("b oor rsv_ready", 64'(rsv_ready_b), 64'd1);
        check("b oor rd_data2", 64'(rd_data_b[95:64]), 64'd0);
        check("b oor rd_busy", 64'(rd_busy_b), 64'd0);
        step();
        check("b oor count", 64'(busy_count_b), 64'd0);
        $display("b out-of-range: ready=%0d count=%0d", rsv_ready_b, busy_count_b);

        // Instance B: R0 is an ordinary register (bypass visible), A keeps it zero.
        idle_inputs();
        wr_en = 1'b1; wr_adr = 5'd0; wr_data = 32'h0BAD; rsv_en = 1'b1; rsv_adr = 5'd0;
        #1;
        check("b r0 bypass", 64'(rd_data_b[95:64]), 64'h0BAD);
        check("a r0 zero", 64'(rd_data_a[31:0]), 64'd0);
        step();
        check("b r0 reserved count", 64'(busy_count_b), 64'd1);
        idle_inputs();
        #1;
        check("b r0 stored", 64'(rd_data_b[31:0]), 64'h0BAD);
        check("b r0 busy", 64'(rd_busy_b[0]), 64'd1);
        step();
        $display("b r0: data=0x%0h busy=%0d count=%0d", rd_data_b[31:0], rd_busy_b[0], busy_count_b);

        // Randomized traffic on both instances against the model.
        for (int c = 0; c < 10000; c++) begin
            wr_en   = 1'($urandom_range(0, 1));
            wr_adr  = 5'($urandom_range(0, 31));
            wr_data = $urandom;
            rsv_en  = 1'($urandom_range(0, 1));
            rsv_adr = 5'($urandom_range(0, 31));
            flush   = ($urandom_range(0, 31) == 0);
            rd_adr  = 15'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                rd_adr[4:0] = wr_adr;
                rd_adr[9:5] = rsv_adr;
            end
            step();
            if (c % 1000 == 0) begin
                $display("random cycle %0d: count_a=%0d count_b=%0d", c, busy_count_a, busy_count_b);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
